// File: rtl/de_stage_reg.sv
// Decode-to-Execute stage register of the 5-stage MIPS core.
// Forwards RD1/RD2 against E/M results and latches decoded fields into E, with bubble insertion.
module de_stage_reg #(
  parameter logic [31:0] PC_RESET = 32'h00003000,
  parameter int          CNT_W    = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             stall,
  input  logic             flush,
  input  logic             d_valid,
  input  logic [31:0]      d_pc,
  input  logic [31:0]      d_instr,
  input  logic [4:0]       d_rs_addr,
  input  logic [4:0]       d_rt_addr,
  input  logic [31:0]      d_rd1,
  input  logic [31:0]      d_rd2,
  input  logic [31:0]      d_imm,
  input  logic [4:0]       d_wa,
  input  logic [1:0]       d_tnew,
  input  logic             e_fwd_en,
  input  logic [4:0]       e_fwd_wa,
  input  logic [31:0]      e_fwd_wd,
  input  logic             m_fwd_en,
  input  logic [4:0]       m_fwd_wa,
  input  logic [31:0]      m_fwd_wd,
  output logic [31:0]      d_rs_fwd,
  output logic [31:0]      d_rt_fwd,
  output logic             e_valid,
  output logic [31:0]      e_pc,
  output logic [31:0]      e_instr,
  output logic [31:0]      e_rs_val,
  output logic [31:0]      e_rt_val,
  output logic [31:0]      e_imm,
  output logic [4:0]       e_wa,
  output logic [1:0]       e_tnew,
  output logic [CNT_W-1:0] bubble_cnt
);

  // Younger producer (E) wins over M; register 0 always reads as zero.
  function automatic logic [31:0] fwd_sel(
    input logic [4:0]  addr,
    input logic [31:0] rd,
    input logic        e_en,
    input logic [4:0]  e_wa_i,
    input logic [31:0] e_wd,
    input logic        m_en,
    input logic [4:0]  m_wa_i,
    input logic [31:0] m_wd
  );
    logic [31:0] res;
    if (addr == 5'd0) begin
      res = 32'd0;
    end else if (e_en && (e_wa_i == addr)) begin
      res = e_wd;
    end else if (m_en && (m_wa_i == addr)) begin
      res = m_wd;
    end else begin
      res = rd;
    end
    return res;
  endfunction

  logic             e_valid_q,  e_valid_d;
  logic [31:0]      e_pc_q,     e_pc_d;
  logic [31:0]      e_instr_q,  e_instr_d;
  logic [31:0]      e_rs_val_q, e_rs_val_d;
  logic [31:0]      e_rt_val_q, e_rt_val_d;
  logic [31:0]      e_imm_q,    e_imm_d;
  logic [4:0]       e_wa_q,     e_wa_d;
  logic [1:0]       e_tnew_q,   e_tnew_d;
  logic [CNT_W-1:0] bubble_cnt_q, bubble_cnt_d;
  logic [31:0]      rs_fwd_s, rt_fwd_s;

  always_comb begin
    rs_fwd_s = fwd_sel(d_rs_addr, d_rd1, e_fwd_en, e_fwd_wa, e_fwd_wd, m_fwd_en, m_fwd_wa, m_fwd_wd);
    rt_fwd_s = fwd_sel(d_rt_addr, d_rd2, e_fwd_en, e_fwd_wa, e_fwd_wd, m_fwd_en, m_fwd_wa, m_fwd_wd);
  end

  always_comb begin
    e_valid_d    = e_valid_q;
    e_pc_d       = e_pc_q;
    e_instr_d    = e_instr_q;
    e_rs_val_d   = e_rs_val_q;
    e_rt_val_d   = e_rt_val_q;
    e_imm_d      = e_imm_q;
    e_wa_d       = e_wa_q;
    e_tnew_d     = e_tnew_q;
    bubble_cnt_d = bubble_cnt_q;

    if (stall || flush) begin
      // PC is kept even in a bubble so exceptions can still report it.
      e_valid_d  = 1'b0;
      e_pc_d     = d_pc;
      e_instr_d  = 32'd0;
      e_rs_val_d = 32'd0;
      e_rt_val_d = 32'd0;
      e_imm_d    = 32'd0;
      e_wa_d     = 5'd0;
      e_tnew_d   = 2'd0;
    end else begin
      e_valid_d  = d_valid;
      e_pc_d     = d_pc;
      e_instr_d  = d_instr;
      e_rs_val_d = rs_fwd_s;
      e_rt_val_d = rt_fwd_s;
      e_imm_d    = d_imm;
      e_wa_d     = d_valid ? d_wa : 5'd0;
      e_tnew_d   = d_tnew;
    end

    if (stall && (bubble_cnt_q != {CNT_W{1'b1}})) begin
      bubble_cnt_d = bubble_cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
    end else begin
      bubble_cnt_d = bubble_cnt_q;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      e_valid_q    <= 1'b0;
      e_pc_q       <= PC_RESET;
      e_instr_q    <= 32'd0;
      e_rs_val_q   <= 32'd0;
      e_rt_val_q   <= 32'd0;
      e_imm_q      <= 32'd0;
      e_wa_q       <= 5'd0;
      e_tnew_q     <= 2'd0;
      bubble_cnt_q <= {CNT_W{1'b0}};
    end else begin
      e_valid_q    <= e_valid_d;
      e_pc_q       <= e_pc_d;
      e_instr_q    <= e_instr_d;
      e_rs_val_q   <= e_rs_val_d;
      e_rt_val_q   <= e_rt_val_d;
      e_imm_q      <= e_imm_d;
      e_wa_q       <= e_wa_d;
      e_tnew_q     <= e_tnew_d;
      bubble_cnt_q <= bubble_cnt_d;
    end
  end

  assign d_rs_fwd   = rs_fwd_s;
  assign d_rt_fwd   = rt_fwd_s;
  assign e_valid    = e_valid_q;
  assign e_pc       = e_pc_q;
  assign e_instr    = e_instr_q;
  assign e_rs_val   = e_rs_val_q;
  assign e_rt_val   = e_rt_val_q;
  assign e_imm      = e_imm_q;
  assign e_wa       = e_wa_q;
  assign e_tnew     = e_tnew_q;
  assign bubble_cnt = bubble_cnt_q;

endmodule

// File: doc/de_stage_reg.md
Name: de_stage_reg

Overview:
- Decode-to-Execute pipeline stage of the 5-stage MIPS core, directly downstream of the register file read ports.
- Forwards the register file RD1/RD2 values against results still in flight in E and M. Exposes the forwarded values combinationally for D-stage branch compare, and latches them with the decoded instruction fields into the E-stage register.
- Inserts bubbles on hazard stall or flush, and keeps a saturating bubble counter for performance debug.

Parameters:
- PC_RESET, 32'h00003000, e_pc value after reset.
- CNT_W, 16, width of the bubble counter.

Ports:
- clk  in  1  clock; all state updates on posedge.
- reset  in  1  synchronous, active-high reset.
- stall  in  1  hazard unit request: load a bubble into E this edge.
- flush  in  1  control-flow flush: load a bubble into E this edge.
- d_valid  in  1  D holds a real instruction.
- d_pc  in  32  D-stage PC.
- d_instr  in  32  D-stage instruction word.
- d_rs_addr  in  5  rs index, same as register file A1.
- d_rt_addr  in  5  rt index, same as register file A2.
- d_rd1  in  32  register file RD1 (already W-bypassed).
- d_rd2  in  32  register file RD2 (already W-bypassed).
- d_imm  in  32  extended immediate.
- d_wa  in  5  destination register, 0 = no write.
- d_tnew  in  2  cycles from E entry until the result exists.
- e_fwd_en  in  1  E-stage result valid for forwarding.
- e_fwd_wa  in  5  E-stage destination.
- e_fwd_wd  in  32  E-stage result.
- m_fwd_en  in  1  M-stage result valid for forwarding.
- m_fwd_wa  in  5  M-stage destination.
- m_fwd_wd  in  32  M-stage result.
- d_rs_fwd  out  32  forwarded rs value, combinational.
- d_rt_fwd  out  32  forwarded rt value, combinational.
- e_valid, e_pc, e_instr, e_rs_val, e_rt_val, e_imm, e_wa, e_tnew  out  1/32/32/32/32/32/5/2  E-stage register contents.
- bubble_cnt  out  CNT_W  bubbles inserted by stall.

Behaviour:
- Forward mux (rs shown; rt identical), evaluated in this order:
  - addr == 0 -> 0.
  - e_fwd_en and e_fwd_wa == addr -> e_fwd_wd.
  - m_fwd_en and m_fwd_wa == addr -> m_fwd_wd.
  - otherwise d_rd1.
- E beats M when both match (younger producer wins). A source whose wa is 0 never forwards.
- Each posedge, priority reset > (stall | flush) > load:
  - reset: e_valid=0, e_pc=PC_RESET, e_instr=0, e_rs_val=0, e_rt_val=0, e_imm=0, e_wa=0, e_tnew=0, bubble_cnt=0.
  - bubble: e_valid=0, e_instr=0, e_rs_val=0, e_rt_val=0, e_imm=0, e_wa=0, e_tnew=0. e_pc=d_pc is retained for later exception PC tracking.
  - load: e_valid=d_valid, e_pc=d_pc, e_instr=d_instr, e_rs_val=d_rs_fwd, e_rt_val=d_rt_fwd, e_imm=d_imm, e_tnew=d_tnew. e_wa=d_wa if d_valid, else 0.
- Latency: 1 cycle from D inputs to E outputs. d_rs_fwd/d_rt_fwd have 0 latency and no register.
- bubble_cnt increments by 1 on an edge where stall=1 and reset=0, including when flush=1 the same edge. It saturates at all-ones and does not wrap. flush alone does not count.
- Reset asserted mid-stall: reset wins that edge; counting resumes the next edge.
- Back-to-back stalls: one bubble per cycle. E stays zeroed until the first non-stalled edge.
- d_valid=0 with no stall loads a non-writing entry (e_wa=0), so it never produces a false forward downstream.
- No combinational path from any output back to stall or flush.

Test Plan:
- Reset: reset=1 for 2 cycles -> e_pc=32'h00003000, all other E outputs 0, bubble_cnt=0.
- Forward priority: rs=5, d_rd1=0x11, e_fwd(en,5,0x22), m_fwd(en,5,0x33) -> d_rs_fwd=0x22. Next edge -> e_rs_val=0x22. Drop e_fwd_en -> d_rs_fwd=0x33.
- $zero guard: rs=0, e_fwd(en,0,0xDEAD) -> d_rs_fwd=0 and e_rs_val=0.
- Stall: d_pc=0x3008, d_wa=8, stall=1 for 3 edges -> e_valid=0, e_wa=0, e_pc=0x3008, bubble_cnt=3. Release -> e_wa=8 and e_valid=1 after one edge.
- Flush+stall same edge -> bubble and bubble_cnt+1. Flush alone -> bubble, count unchanged.
- Saturation: CNT_W=4, 20 stall edges -> bubble_cnt=15 and holds.
